hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and mult/div interlocks, operand
// forwarding selects from a three-stage destination scoreboard, and a stall counter.
module hazard_ctrl #(
  parameter int unsigned MULDIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_we,
  input  logic        id_is_load,
  input  logic        id_is_muldiv,
  input  logic        id_reads_hilo,
  input  logic        ex_branch_taken,
  output logic        stall,
  output logic        issue,
  output logic        flush_ifid,
  output logic        bubble_ex,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        muldiv_busy,
  output logic [15:0] stall_cycles
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned SC_W  = 16;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);
  localparam logic [SC_W-1:0]  SC_MAX   = {SC_W{1'b1}};

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             load;
  } sb_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  sb_entry_t ex_q, mem_q, wb_q;
  sb_entry_t ex_d;
  state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SC_W-1:0]  stall_cycles_q;

  logic load_use_c;
  logic muldiv_conflict_c;

  // Register 0 is hard-wired, so an entry writing it never produces a match.
  function automatic logic sb_hit(input sb_entry_t e, input logic [REG_W-1:0] r);
    return e.valid && (e.rd != REG_W'(0)) && (e.rd == r);
  endfunction

  // A load still in EX has no data yet, so it is never a forwarding source.
  function automatic logic [1:0] fwd_sel(input sb_entry_t ex, input sb_entry_t mem,
                                         input sb_entry_t wb, input logic [REG_W-1:0] r);
    logic [1:0] sel;
    sel = FWD_RF;
    if (sb_hit(ex, r) && !ex.load) begin
      sel = FWD_EX;
    end else if (sb_hit(mem, r)) begin
      sel = FWD_MEM;
    end else if (sb_hit(wb, r)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  // Hazard detection and pipeline control; a taken branch overrides every stall.
  always_comb begin
    load_use_c        = id_valid && ex_q.load &&
                        (sb_hit(ex_q, id_rs) || sb_hit(ex_q, id_rt));
    muldiv_conflict_c = id_valid && (id_is_muldiv || id_reads_hilo) && (state_q == BUSY);
    stall             = !ex_branch_taken && (load_use_c || muldiv_conflict_c);
    issue             = id_valid && !stall && !ex_branch_taken;
    flush_ifid        = ex_branch_taken;
    bubble_ex         = ex_branch_taken || stall;
    muldiv_busy       = (state_q == BUSY);
    stall_cycles      = stall_cycles_q;
  end

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (id_valid && !stall) begin
      fwd_a = fwd_sel(ex_q, mem_q, wb_q, id_rs);
      fwd_b = fwd_sel(ex_q, mem_q, wb_q, id_rt);
    end
  end

  always_comb begin
    ex_d = '0;
    if (issue) begin
      ex_d.valid = id_we && (id_rd != REG_W'(0));
      ex_d.rd    = id_rd;
      ex_d.load  = id_is_load;
    end
  end

  // Scoreboard shifts every cycle; a held or flushed instruction leaves a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Mult/div occupancy: busy for exactly MULDIV_LAT cycles after issue.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (issue && id_is_muldiv) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(0)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else if (stall && (stall_cycles_q != SC_MAX)) begin
      stall_cycles_q <= stall_cycles_q + SC_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table through a scoreboard queue,
// plus hand sequences for asynchronous reset and stall-counter saturation.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       md;
    logic       hl;
    logic       br;
    logic [9:0] exp;  // {stall, issue, flush, bubble, fwd_a, fwd_b, busy}
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst2 = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic        id_we = 1'b0, id_is_load = 1'b0, id_is_muldiv = 1'b0;
  logic        id_reads_hilo = 1'b0, ex_branch_taken = 1'b0;
  logic        stall, issue, flush_ifid, bubble_ex, muldiv_busy;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cycles;

  logic        stall2, issue2, flush2, bubble2, busy2;
  logic [1:0]  fwd_a2, fwd_b2;
  logic [15:0] stall_cycles2;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.MULDIV_LAT(4)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .id_is_muldiv(id_is_muldiv),
    .id_reads_hilo(id_reads_hilo), .ex_branch_taken(ex_branch_taken),
    .stall(stall), .issue(issue), .flush_ifid(flush_ifid), .bubble_ex(bubble_ex),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .muldiv_busy(muldiv_busy), .stall_cycles(stall_cycles)
  );

  // Frozen load + mult/div with a long latency keeps this instance stalled almost every cycle.
  hazard_ctrl #(.MULDIV_LAT(255)) u_sat (
    .clk(clk), .rst(rst2), .id_valid(1'b1), .id_rs(5'd5), .id_rt(5'd0),
    .id_rd(5'd5), .id_we(1'b1), .id_is_load(1'b1), .id_is_muldiv(1'b1),
    .id_reads_hilo(1'b0), .ex_branch_taken(1'b0),
    .stall(stall2), .issue(issue2), .flush_ifid(flush2), .bubble_ex(bubble2),
    .fwd_a(fwd_a2), .fwd_b(fwd_b2), .muldiv_busy(busy2), .stall_cycles(stall_cycles2)
  );

  function automatic vec_t mk(int v, int rs, int rt, int rd, int we, int ld, int md,
                              int hl, int br, int st, int is, int fl, int bu,
                              int fa, int fb, int bz);
    vec_t r;
    r.valid = 1'(v);  r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd);
    r.we = 1'(we);    r.ld = 1'(ld); r.md = 1'(md); r.hl = 1'(hl); r.br = 1'(br);
    r.exp = {1'(st), 1'(is), 1'(fl), 1'(bu), 2'(fa), 2'(fb), 1'(bz)};
    return r;
  endfunction

  task automatic drive(input vec_t v);
    id_valid = v.valid; id_rs = v.rs; id_rt = v.rt; id_rd = v.rd; id_we = v.we;
    id_is_load = v.ld; id_is_muldiv = v.md; id_reads_hilo = v.hl; ex_branch_taken = v.br;
    exp_q.push_back(v.exp);
  endtask

  task automatic check_out(input string nm);
    logic [9:0] act;
    logic [9:0] e;
    act = {stall, issue, flush_ifid, bubble_ex, fwd_a, fwd_b, muldiv_busy};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected entry queued, got %b", nm, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got {st,is,fl,bu,fa,fb,busy}=%b expected %b", nm, act, e);
      end
    end
  endtask

  task automatic check_val(input string nm, input logic [15:0] act, input logic [15:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, e);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    check_out(nm);
  endtask

  initial begin
    // Reset state, sampled while rst is still asserted.
    #2;
    drive(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    check_out("reset_outputs");
    check_val("reset_stall_cycles", stall_cycles, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    rst2 = 1'b0;

    // Forwarding, load-use, register 0 and branch-priority vectors.
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));  // first cycle after reset
    tbl.push_back(mk(1,1,2,5,1,1,0,0,0, 0,1,0,0,0,0,0));  // lw r5
    tbl.push_back(mk(1,5,0,6,1,0,0,0,0, 1,0,0,1,0,0,0));  // use r5: stall
    tbl.push_back(mk(1,5,0,6,1,0,0,0,0, 0,1,0,0,2,0,0));  // retry: fwd from MEM
    tbl.push_back(mk(1,0,0,3,1,0,0,0,0, 0,1,0,0,0,0,0));  // add r3
    tbl.push_back(mk(1,7,3,0,0,0,0,0,0, 0,1,0,0,0,1,0));  // rt=3 from EX
    tbl.push_back(mk(1,6,3,0,0,0,0,0,0, 0,1,0,0,3,2,0));  // r6 from WB, r3 from MEM
    tbl.push_back(mk(1,0,3,0,0,0,0,0,0, 0,1,0,0,0,3,0));  // r3 from WB
    tbl.push_back(mk(1,0,0,9,1,0,0,0,0, 0,1,0,0,0,0,0));  // write r9
    tbl.push_back(mk(1,9,0,9,1,0,0,0,0, 0,1,0,0,1,0,0));  // write r9 again
    tbl.push_back(mk(1,9,9,0,0,0,0,0,0, 0,1,0,0,1,1,0));  // EX beats MEM
    tbl.push_back(mk(1,9,0,0,0,0,0,0,0, 0,1,0,0,2,0,0));  // MEM beats WB
    tbl.push_back(mk(1,0,0,0,1,1,0,0,0, 0,1,0,0,0,0,0));  // load to r0
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 0,1,0,0,0,0,0));  // rs=0: no hazard
    tbl.push_back(mk(1,0,0,4,1,1,0,0,0, 0,1,0,0,0,0,0));  // lw r4
    tbl.push_back(mk(1,4,0,0,0,0,0,0,1, 0,0,1,1,0,0,0));  // load-use + branch
    tbl.push_back(mk(1,4,0,0,0,0,0,0,0, 0,1,0,0,2,0,0));  // EX was a bubble
    tbl.push_back(mk(0,4,4,0,0,0,0,0,0, 0,0,0,0,0,0,0));  // invalid: fwd forced 00
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("fwd_tbl[%0d]", i));
    check_val("stall_cycles_after_load_use", stall_cycles, 16'd1);

    // Mult/div interlock with MULDIV_LAT=4.
    tbl.delete();
    tbl.push_back(mk(1,0,0,0,0,0,1,0,0, 0,1,0,0,0,0,0));  // mult
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1,0,0,8,1,0,0,1,0, 1,0,0,1,0,0,1));  // mfhi stalls 4 cycles
    tbl.push_back(mk(1,0,0,8,1,0,0,1,0, 0,1,0,0,0,0,0));  // mfhi issues, unit idle
    tbl.push_back(mk(1,0,0,0,0,0,1,0,1, 0,0,1,1,0,0,0));  // flushed mult
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));  // flushed mult never started
    tbl.push_back(mk(1,0,0,0,0,0,1,0,0, 0,1,0,0,0,0,0));  // mult
    tbl.push_back(mk(1,0,0,8,1,0,0,1,1, 0,0,1,1,0,0,1));  // branch beats busy stall
    tbl.push_back(mk(1,0,0,2,1,0,0,0,0, 0,1,0,0,0,0,1));  // independent op proceeds
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("md_tbl[%0d]", i));
    check_val("stall_cycles_after_muldiv", stall_cycles, 16'd5);

    // Asynchronous reset in the middle of a busy mult/div.
    @(posedge clk);
    #1;
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0; id_we = 1'b0;
    id_is_load = 1'b0; id_is_muldiv = 1'b0; id_reads_hilo = 1'b0; ex_branch_taken = 1'b0;
    #2;
    check_val("busy_before_rst", 16'(muldiv_busy), 16'd1);
    rst = 1'b1;
    #1;
    check_val("busy_async_clear", 16'(muldiv_busy), 16'd0);
    check_val("stall_cycles_async_clear", stall_cycles, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(mk(1,0,0,8,1,0,0,1,0, 0,1,0,0,0,0,0), "mfhi_after_rst");

    // Saturation instance has been stalling since its reset release.
    repeat (70000) @(posedge clk);
    @(negedge clk);
    check_val("stall_cycles_saturate", stall_cycles2, 16'hFFFF);
    check_val("saturate_still_stalling", 16'(stall2 | issue2), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
